// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with a registered read port. It provides an
// occupancy count, run-time almost-full/almost-empty thresholds, a synchronous
// flush and sticky overflow/underflow flags that are cleared explicitly.
//
// Parameters
//   DATA_W      data width in bits (>= 1)
//   ADDR_W      address width, DEPTH = 2**ADDR_W entries (>= 1)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   flush         synchronous clear of pointers and rd_valid
//   wr, data_in   write request and write data
//   rd            read request
//   data_out      registered read data (holds when no read is accepted)
//   rd_valid      one-cycle strobe: data_out holds a freshly popped word
//   count         occupancy 0..DEPTH
//   full, empty   occupancy == DEPTH / occupancy == 0
//   afull_lvl     almost_full  = count >= afull_lvl
//   aempty_lvl    almost_empty = count <= aempty_lvl
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
//   err_clr       clears overflow/underflow (a same-cycle set wins)
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W:0]   afull_lvl,
    input  logic [ADDR_W:0]   aempty_lvl,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Storage is deliberately not reset so it can map onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    logic [ADDR_W:0]   wptr_reg;
    logic [ADDR_W:0]   rptr_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              rd_valid_reg;
    logic              overflow_reg;
    logic              underflow_reg;

    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              udf_set;

    // Modulo subtraction of the wrap-extended pointers gives 0..DEPTH.
    assign count = wptr_reg - rptr_reg;
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Unsigned compares give the edge behaviour for free: afull_lvl == 0
    // always passes, and aempty_lvl >= DEPTH always passes.
    assign almost_full  = (count >= afull_lvl);
    assign almost_empty = (count <= aempty_lvl);

    // Accepts look only at registered state, so a read in the same cycle
    // never makes room for a write into a full FIFO (and vice versa).
    // Flush suppresses both accesses and both error sets.
    assign wr_acc  = wr & ~full  & ~flush;
    assign rd_acc  = rd & ~empty & ~flush;
    assign ovf_set = wr & full  & ~flush;
    assign udf_set = rd & empty & ~flush;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_reg[ADDR_W-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            data_out_reg  <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            // data_out and the sticky flags are intentionally left alone.
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_reg     <= rptr_reg + PTR_ONE;
                data_out_reg <= mem[rptr_reg[ADDR_W-1:0]];
            end
            rd_valid_reg <= rd_acc;

            // Set has priority over a simultaneous clear.
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
            if (udf_set) begin
                underflow_reg <= 1'b1;
            end else if (err_clr) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign data_out  = data_out_reg;
    assign rd_valid  = rd_valid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param (DATA_W = 8, ADDR_W = 4). A queue
// based reference model predicts every output after every clock. A table of
// hand-computed vectors, directed corner-case sequences and a randomized
// phase drive the design.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   afull_lvl;
    logic [ADDR_W:0]   aempty_lvl;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic              err_clr;

    sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr           (wr),
        .data_in      (data_in),
        .rd           (rd),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .afull_lvl    (afull_lvl),
        .aempty_lvl   (aempty_lvl),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_ovf;
    logic       m_udf;
    logic       m_in_rst;

    task automatic m_reset();
        m_q.delete();
        m_dout   = 8'h00;
        m_valid  = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_in_rst = 1'b1;
    endtask

    // Predicts the effect of one rising edge from the current model contents.
    task automatic m_step(input logic f, input logic w, input logic [7:0] d,
                          input logic r, input logic e);
        bit was_full;
        bit was_empty;
        if (m_in_rst) return;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (f) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (r && !was_empty) begin
                m_dout  = m_q.pop_front();
                m_valid = 1'b1;
            end
            if (w && !was_full) m_q.push_back(d);
            if (w && was_full) m_ovf = 1'b1;
            else if (e)        m_ovf = 1'b0;
            if (r && was_empty) m_udf = 1'b1;
            else if (e)         m_udf = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("count",        32'(count),        32'(n));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= int'(afull_lvl)));
        chk("almost_empty", 32'(almost_empty), 32'(n <= int'(aempty_lvl)));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
        chk("rd_valid",     32'(rd_valid),     32'(m_valid));
        chk("data_out",     32'(data_out),     32'(m_dout));
    endtask

    // One transaction: drive inputs, predict, clock, check, log one line.
    task automatic cycle(input logic f, input logic w, input logic [7:0] d,
                         input logic r, input logic e);
        flush   = f;
        wr      = w;
        data_in = d;
        rd      = r;
        err_clr = e;
        m_step(f, w, d, r, e);
        @(posedge clk);
        #1;
        check_model();
        $display("txn f=%b w=%b d=%h r=%b e=%b -> cnt=%0d v=%b dout=%h ovf=%b udf=%b",
                 f, w, d, r, e, count, rd_valid, data_out, overflow, underflow);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       f, w;
        logic [7:0] d;
        logic       r, e;
        int         cnt;
        logic       v;
        logic [7:0] dout;
        logic       full, empty, ovf, udf;
    } vec_t;

    function automatic vec_t mkv(logic f, logic w, logic [7:0] d, logic r, logic e,
                                 int cnt, logic v, logic [7:0] dout,
                                 logic fl, logic em, logic ovf, logic udf);
        vec_t x;
        x.f = f; x.w = w; x.d = d; x.r = r; x.e = e;
        x.cnt = cnt; x.v = v; x.dout = dout;
        x.full = fl; x.empty = em; x.ovf = ovf; x.udf = udf;
        return x;
    endfunction

    vec_t tbl[11];

    initial begin
        int written;
        int occ;
        int guard;
        logic w_r;
        logic r_r;

        //                 f  w  d      r  e   cnt v  dout   full empty ovf udf
        tbl[0]  = mkv(0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 0, 1); // read empty
        tbl[1]  = mkv(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 0, 0); // clear
        tbl[2]  = mkv(0, 1, 8'hA1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 8'hB2, 0, 0, 2, 0, 8'h00, 0, 0, 0, 0);
        tbl[4]  = mkv(0, 1, 8'hC3, 1, 0, 2, 1, 8'hA1, 0, 0, 0, 0); // wr+rd
        tbl[5]  = mkv(0, 0, 8'h00, 0, 0, 2, 0, 8'hA1, 0, 0, 0, 0); // dout holds
        tbl[6]  = mkv(0, 0, 8'h00, 1, 0, 1, 1, 8'hB2, 0, 0, 0, 0);
        tbl[7]  = mkv(1, 1, 8'h77, 1, 0, 0, 0, 8'hB2, 0, 1, 0, 0); // flush wins
        tbl[8]  = mkv(0, 0, 8'h00, 1, 1, 0, 0, 8'hB2, 0, 1, 0, 1); // set beats clr
        tbl[9]  = mkv(0, 1, 8'h5A, 1, 0, 1, 0, 8'hB2, 0, 0, 0, 1); // rd rejected
        tbl[10] = mkv(0, 0, 8'h00, 1, 1, 0, 1, 8'h5A, 0, 1, 0, 0); // rd ok, clr

        // ---------------- reset ----------------
        rst_n = 1'b0; flush = 0; wr = 0; rd = 0; err_clr = 0; data_in = '0;
        afull_lvl = '0; aempty_lvl = 5'd3;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("reset_afull_lvl0", 32'(almost_full), 32'd1);
        chk("reset_empty", 32'(empty), 32'd1);
        afull_lvl = 5'd12;
        #1;
        chk("reset_afull_lvl12", 32'(almost_full), 32'd0);
        rst_n = 1'b1;
        m_in_rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].f, tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].e);
            chk($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid),  32'(tbl[i].v));
            chk($sformatf("tbl%0d_dout",  i), 32'(data_out),  32'(tbl[i].dout));
            chk($sformatf("tbl%0d_full",  i), 32'(full),      32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(empty),     32'(tbl[i].empty));
            chk($sformatf("tbl%0d_ovf",   i), 32'(overflow),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf",   i), 32'(underflow), 32'(tbl[i].udf));
        end

        // ---------------- fill, overflow, drain ----------------
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cycle(0, 1, 8'hAA, 1, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd15);
        chk("ovf_first_read", 32'(data_out), 32'h00);
        for (int i = 1; i < 16; i++) begin
            cycle(0, 0, 8'h00, 1, 0);
            chk("drain_data", 32'(data_out), 32'(i));
            chk("drain_valid", 32'(rd_valid), 32'd1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cycle(0, 0, 8'h00, 0, 1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // ---------------- underflow ----------------
        cycle(0, 0, 8'h00, 1, 0);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_no_valid", 32'(rd_valid), 32'd0);
        chk("udf_dout_hold", 32'(data_out), 32'h0F);
        cycle(0, 0, 8'h00, 1, 1);
        chk("udf_set_wins", 32'(underflow), 32'd1);
        cycle(0, 0, 8'h00, 0, 1);

        // ---------------- thresholds ----------------
        afull_lvl = 5'd12; aempty_lvl = 5'd3;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 8'h40 + 8'(i), 0, 0);
            chk("thr_afull", 32'(almost_full), 32'(i + 1 >= 12));
            chk("thr_aempty", 32'(almost_empty), 32'(i + 1 <= 3));
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 8'h60 + 8'(i), 1, 0);
            chk("thr_count_steady", 32'(count), 32'd12);
            chk("thr_order", 32'(data_out), 32'(8'h40 + 8'(i)));
        end
        while (m_q.size() > 0) cycle(0, 0, 8'h00, 1, 0);

        // ---------------- wrap-around at low occupancy ----------------
        written = 0;
        guard = 0;
        cycle(0, 1, 8'(written), 0, 0);
        written++;
        while (written < 52 && guard < 600) begin
            occ = m_q.size();
            w_r = (occ < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_r = (occ > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycle(0, w_r, 8'(written), r_r, 0);
            if (w_r) written++;
            guard++;
        end
        chk("wrap_words", 32'(written >= 52), 32'd1);
        while (m_q.size() > 0) cycle(0, 0, 8'h00, 1, 0);

        // ---------------- flush ----------------
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'h90 + 8'(i), 0, 0);
        cycle(1, 1, 8'h55, 1, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_valid", 32'(rd_valid), 32'd0);
        cycle(0, 1, 8'h33, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        chk("post_flush_read", 32'(data_out), 32'h33);

        // ---------------- asynchronous reset mid-burst ----------------
        for (int i = 0; i < 4; i++) cycle(0, 1, 8'hC0 + 8'(i), i[0], 0);
        cycle(0, 1, 8'hEE, 0, 0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_model();
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_dout", 32'(data_out), 32'd0);
        cycle(0, 1, 8'hE1, 1, 0);
        cycle(0, 1, 8'hE2, 0, 0);
        wr = 1'b0;
        #2;
        rst_n = 1'b1;
        m_in_rst = 1'b0;
        cycle(0, 0, 8'h00, 1, 0);
        chk("post_rst_udf", 32'(underflow), 32'd1);
        cycle(0, 1, 8'h12, 0, 1);
        cycle(0, 0, 8'h00, 1, 0);
        chk("post_rst_data", 32'(data_out), 32'h12);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 1500; i++) begin
            int wb;
            if (i % 100 == 0) begin
                afull_lvl  = 5'($urandom_range(0, 20));
                aempty_lvl = 5'($urandom_range(0, 20));
            end
            wb = ((i / 250) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 99) < wb),
                  8'($urandom),
                  ($urandom_range(0, 99) < 100 - wb),
                  ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
